// File: rtl/weight_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_stream_pkg
// Description : Shared defaults and state encoding for the weight stream
//               reader and its read-data skid FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package weight_stream_pkg;

  // Default geometry: 28 words of 16 bits behind a 5-bit BRAM address
  localparam int c_DEPTH_DEFAULT = 28;
  localparam int c_DW_DEFAULT    = 16;
  localparam int c_AW_DEFAULT    = 5;

  // Read-data FIFO holds two words: one in flight plus one being presented
  localparam logic [1:0] c_FIFO_DEPTH = 2'd2;

  // Reader state encoding
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_FETCH  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN  = 2'd2;
  localparam logic [1:0] c_ST_FINISH = 2'd3;

endpackage : weight_stream_pkg
`default_nettype wire

// File: rtl/weight_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : weight_skid_fifo
// Description : Two-entry FIFO decoupling BRAM read returns from the weight
//               consumer. Head word is presented combinationally; a push and
//               pop in the same cycle leave the occupancy unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_skid_fifo
  import weight_stream_pkg::*;
#(
  parameter int DW = c_DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  // A pop only takes effect on a non-empty FIFO, a push only when not full
  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_push  = i_push && (r_count != c_FIFO_DEPTH);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == c_FIFO_DEPTH);
  assign o_empty = (r_count == 2'd0);

  // Storage, pointers and occupancy; reset clears storage so the head reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : weight_skid_fifo
`default_nettype wire

// File: rtl/weight_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : weight_stream_reader
// Description : Streams DEPTH weight words from a falling-edge BRAM to a
//               valid/ready consumer through a two-entry skid FIFO.
//               Optional feature macro: WEIGHT_CHECKSUM_EN adds a CHECKSUM
//               output holding the modulo-2**DW sum of the delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_stream_reader
  import weight_stream_pkg::*;
#(
  parameter int DEPTH = c_DEPTH_DEFAULT,
  parameter int DW    = c_DW_DEFAULT,
  parameter int AW    = c_AW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] BRAM_ADDR,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  output logic [DW-1:0] BRAM_DI,
  input  logic [DW-1:0] BRAM_DO,
  output logic [DW-1:0] W_DATA,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST,
  output logic [AW-1:0] W_INDEX
`ifdef WEIGHT_CHECKSUM_EN
  ,
  output logic [DW-1:0] CHECKSUM
`endif
);

  // Read counter needs one extra bit so it can reach DEPTH itself
  localparam logic [AW:0]   c_DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_LAST_IDX  = AW'(DEPTH - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_rd_cnt;
  logic [AW-1:0] r_del_cnt;
  logic          w_start_ok;
  logic          w_issue;
  logic          w_hs;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [DW-1:0] w_fifo_head;

  // START is only honoured from IDLE; FINISH and active states drop it
  assign w_start_ok = (r_state == c_ST_IDLE) && START;

  // Issue a read while room remains in the FIFO and words are still owed
  assign w_issue = (r_state == c_ST_FETCH) && !w_fifo_full && (r_rd_cnt < c_DEPTH_CNT);

  assign w_hs = W_VALID && W_READY;

  // Read data lands in the FIFO at the edge that closes the issue cycle
  weight_skid_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk         (CLK),
    .rst         (RST),
    .i_push      (w_issue),
    .i_push_data (BRAM_DO),
    .i_pop       (w_hs),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign W_VALID   = !w_fifo_empty;
  assign W_DATA    = w_fifo_head;
  assign W_INDEX   = r_del_cnt;
  assign W_LAST    = W_VALID && (r_del_cnt == c_LAST_IDX);
  assign BRAM_ADDR = r_addr;
  assign BRAM_WE   = 1'b0;
  assign BRAM_DI   = '0;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (START) begin
          w_next_state = c_ST_FETCH;
        end
      end
      c_ST_FETCH: begin
        if (w_issue && (r_rd_cnt == c_DEPTH_CNT - 1'b1)) begin
          w_next_state = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (w_hs && W_LAST) begin
          w_next_state = c_ST_FINISH;
        end
      end
      default: begin
        w_next_state = c_ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    BUSY    = (r_state == c_ST_FETCH) || (r_state == c_ST_DRAIN);
    DONE    = (r_state == c_ST_FINISH);
    BRAM_EN = w_issue;
  end

  // Address, read and delivery counters; address parks on the last word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr    <= '0;
      r_rd_cnt  <= '0;
      r_del_cnt <= '0;
    end else if (w_start_ok) begin
      r_addr    <= '0;
      r_rd_cnt  <= '0;
      r_del_cnt <= '0;
    end else begin
      if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        if (r_addr != c_LAST_IDX) begin
          r_addr <= r_addr + 1'b1;
        end
      end
      if (w_hs && !W_LAST) begin
        r_del_cnt <= r_del_cnt + 1'b1;
      end
    end
  end

`ifdef WEIGHT_CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  // Running sum of delivered words, cleared by an accepted START
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + W_DATA;
    end
  end

  assign CHECKSUM = r_checksum;
`endif

endmodule : weight_stream_reader
`default_nettype wire

// File: tb/tb_weight_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_weight_stream_reader
// Description : Self-checking bench for weight_stream_reader. A falling-edge
//               BRAM model feeds the reader; a word-level model (occupancy,
//               issued reads, delivered words) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_stream_reader;

  localparam int DEPTH = 28;
  localparam int DW    = 16;
  localparam int AW    = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] BRAM_ADDR;
  logic          BRAM_EN;
  logic          BRAM_WE;
  logic [DW-1:0] BRAM_DI;
  logic [DW-1:0] BRAM_DO = '0;
  logic [DW-1:0] W_DATA;
  logic          W_VALID;
  logic          W_READY;
  logic          W_LAST;
  logic [AW-1:0] W_INDEX;
`ifdef WEIGHT_CHECKSUM_EN
  logic [DW-1:0] CHECKSUM;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [2**AW];

  int done_count;
  int done_cycle;
  int issues_at10;
  int rst_hit;

  weight_stream_reader #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_EN   (BRAM_EN),
    .BRAM_WE   (BRAM_WE),
    .BRAM_DI   (BRAM_DI),
    .BRAM_DO   (BRAM_DO),
    .W_DATA    (W_DATA),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .W_LAST    (W_LAST),
    .W_INDEX   (W_INDEX)
`ifdef WEIGHT_CHECKSUM_EN
    ,
    .CHECKSUM  (CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  // Weight BRAM: samples address on the falling edge of an enabled cycle
  always @(negedge CLK) begin
    if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      BUSY,      0);
    check({tag, "_done"},      DONE,      0);
    check({tag, "_bram_en"},   BRAM_EN,   0);
    check({tag, "_bram_addr"}, BRAM_ADDR, 0);
    check({tag, "_w_valid"},   W_VALID,   0);
    check({tag, "_w_last"},    W_LAST,    0);
    check({tag, "_w_index"},   W_INDEX,   0);
    check({tag, "_w_data"},    W_DATA,    0);
  endtask

  // Consumer readiness: 0 always, 1 pattern 1,0,0,1, 2 stalled 10 cycles, 3 random
  function automatic logic ready_for(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return ((n - 1) % 4 == 0) || ((n - 1) % 4 == 3);
      2:       return (n > 10);
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
  endtask

  // One pass: START at cycle 0, optional second START, optional reset at a word
  task automatic run_pass(input int mode, input int start_again, input int rst_word);
    int occ = 0;
    int issues = 0;
    int idx = 0;
    int last_hs = -1;
    int stop_n = 200;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_index = '0;
    logic prev_last = 1'b0;
    logic [DW-1:0] sum = '0;
    logic hs;
    done_count  = 0;
    done_cycle  = -1;
    issues_at10 = -1;
    rst_hit     = 0;
    @(posedge CLK); #1;
    START   = 1'b1;
    W_READY = ready_for(mode, 0);
    @(posedge CLK); #1;
    START   = 1'b0;
    for (int n = 1; n <= stop_n; n++) begin
      if (rst_word >= 0 && idx == rst_word) begin
        RST = 1'b1;
        #2;
        check_reset_outputs("rst_now");
        @(negedge CLK);
        check_reset_outputs("rst_hold");
        @(posedge CLK); #1;
        check_reset_outputs("rst_edge");
        RST = 1'b0;
        rst_hit = 1;
        break;
      end
      START   = (n == start_again);
      W_READY = ready_for(mode, n);
      @(negedge CLK);
      hs = W_VALID && W_READY;
      check("w_valid", W_VALID, occ > 0);
      check("bram_en", BRAM_EN, (occ < 2) && (issues < DEPTH));
      check("busy",    BUSY,    last_hs < 0);
      check("done",    DONE,    (last_hs >= 0) && (n == last_hs + 1));
      check("w_last",  W_LAST,  (occ > 0) && (idx == DEPTH - 1));
      check("bram_we", BRAM_WE, 0);
      check("bram_di", BRAM_DI, 0);
      if (prev_stall) begin
        check("stall_valid", W_VALID, 1);
        check("stall_data",  W_DATA,  prev_data);
        check("stall_index", W_INDEX, prev_index);
        check("stall_last",  W_LAST,  prev_last);
      end
      if (BRAM_EN) begin
        check("bram_addr", BRAM_ADDR, issues);
        issues++;
      end
      if (W_VALID) check("w_index", W_INDEX, idx);
      if (hs) begin
        if (idx < DEPTH) begin
          check("w_data", W_DATA, mem[idx]);
        end else begin
          check("word_count", idx + 1, DEPTH);
        end
        sum = sum + W_DATA;
        idx++;
        if (idx == DEPTH) last_hs = n;
      end
      if (DONE) begin
        done_count++;
        done_cycle = n;
`ifdef WEIGHT_CHECKSUM_EN
        check("checksum", CHECKSUM, sum);
`endif
        stop_n = n + 3;
      end
      occ = occ + int'(BRAM_EN) - int'(hs);
      prev_stall = W_VALID && !W_READY;
      prev_data  = W_DATA;
      prev_index = W_INDEX;
      prev_last  = W_LAST;
      if (n == 10) issues_at10 = issues;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    if (rst_hit == 0) begin
      check("done_count", done_count, 1);
      check("words", idx, DEPTH);
    end
  endtask

  initial begin
    RST     = 1'b1;
    START   = 1'b0;
    W_READY = 1'b0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("por");
    RST = 1'b0;

    // Ramp contents, always ready, START repeated during FINISH
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
    run_pass(0, 30, -1);
    check("done_latency", done_cycle, 30);

    // Ready pattern 1,0,0,1
    fill_random();
    run_pass(1, -1, -1);

    // Consumer stalled for 10 cycles after START
    fill_random();
    run_pass(2, -1, -1);
    check("stall_reads", issues_at10, 2);

    // Second START mid-pass
    fill_random();
    run_pass(0, 10, -1);
    check("restart_latency", done_cycle, 30);

    // Reset at word 12, then a full pass with random readiness
    fill_random();
    run_pass(0, -1, 12);
    check("rst_taken", rst_hit, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("post_rst_done",  DONE,    0);
      check("post_rst_busy",  BUSY,    0);
      check("post_rst_valid", W_VALID, 0);
      @(posedge CLK); #1;
    end
    run_pass(3, -1, -1);

`ifdef WEIGHT_CHECKSUM_EN
    // Constant words: 28 * 0x1000 wraps to 0xC000
    for (int i = 0; i < 2**AW; i++) mem[i] = 16'h1000;
    run_pass(0, -1, -1);
    check("checksum_const", CHECKSUM, 32'h0000_C000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_weight_stream_reader
`default_nettype wire
